spi_slave: RTL and testbench

SPI responder that talks to our SPI master over sclk/cs/mosi/miso, using the same framing in both directions. A frame is a start bit (0), 8 data bits MSB first, then a stop bit (1); lines idle at 1 and cs is active-low. The block oversamples the SPI pins in its own clock domain. It presents a valid/ready byte interface to local logic for transmit and a one-cycle strobe for received bytes.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 42 ++++
 rtl/spi_slave.sv | 147 ++++++++++++++
 tb/tb_spi_slave.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI framing constants and FSM encodings for the slave and master.
package spi_pkg;

  localparam int DATA_BITS = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_DATA = 2'd1;
  localparam logic [1:0] RX_STOP = 2'd2;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_DATA = 2'd1;
  localparam logic [1:0] TX_STOP = 2'd2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchronizer (resets to 1) with optional rise/fall pulses.
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter bit EDGES  = 1'b0
) (
  input  logic clock_in,
  input  logic rs,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous pin through the synchronizer chain.
  always_ff @(posedge clock_in or posedge rs) begin
    if (rs) chain <= '1;
    else    chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

  generate
    if (EDGES) begin : g_edge
      logic q_d;

      // One-cycle delayed copy of the synced level for edge detection.
      always_ff @(posedge clock_in or posedge rs) begin
        if (rs) q_d <= 1'b1;
        else    q_d <= q;
      end

      assign rise = q & ~q_d;
      assign fall = ~q & q_d;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled sclk/cs/mosi, framed RX/TX (start 0, 8 bits MSB first, stop 1).
module spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clock_in,
  input  logic                 rs,
  input  logic                 sclk,
  input  logic                 cs,
  input  logic                 mosi,
  output logic                 miso,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 busy
);

  import spi_pkg::*;

  localparam int                IDX_W   = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  IDX_MSB = IDX_W'(DATA_BITS - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, mosi_s;
  logic cs_rise_unused, cs_fall_unused, mosi_rise_unused, mosi_fall_unused;

  logic [1:0]           rx_state;
  logic [IDX_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_sh;

  logic [1:0]           tx_state;
  logic [IDX_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_sh;
  logic [DATA_BITS-1:0] hold;
  logic                 full;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_sclk (
    .clock_in(clock_in), .rs(rs), .d(sclk),
    .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGES(1'b0)) u_sync_cs (
    .clock_in(clock_in), .rs(rs), .d(cs),
    .q(cs_s), .rise(cs_rise_unused), .fall(cs_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGES(1'b0)) u_sync_mosi (
    .clock_in(clock_in), .rs(rs), .d(mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // RX control: frame tracking on sclk falls, registered valid/error strobes.
  always_ff @(posedge clock_in or posedge rs) begin
    if (rs) begin
      rx_state     <= RX_IDLE;
      rx_idx       <= IDX_MSB;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      if (cs_s) begin
        rx_state <= RX_IDLE;
      end else if (sclk_fall) begin
        case (rx_state)
          RX_IDLE: begin
            if (mosi_s == START_BIT) begin
              rx_state <= RX_DATA;
              rx_idx   <= IDX_MSB;
            end
          end
          RX_DATA: begin
            if (rx_idx == '0) rx_state <= RX_STOP;
            else              rx_idx   <= rx_idx - 1'b1;
          end
          RX_STOP: begin
            if (mosi_s == STOP_BIT) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
            rx_state <= RX_IDLE;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // RX datapath: capture mosi at the current bit index, MSB first.
  always_ff @(posedge clock_in) begin
    if (!cs_s && sclk_fall && rx_state == RX_DATA) rx_sh[rx_idx] <= mosi_s;
  end

  // TX control: holding-register flag and miso sequencing on sclk rises.
  always_ff @(posedge clock_in or posedge rs) begin
    if (rs) begin
      full     <= 1'b0;
      tx_state <= TX_IDLE;
      tx_idx   <= IDX_MSB;
      miso     <= IDLE_LEVEL;
    end else begin
      // Load needs !full and consume needs full, so they never collide.
      if (tx_valid && !full) full <= 1'b1;
      if (cs_s) begin
        tx_state <= TX_IDLE;
        miso     <= IDLE_LEVEL;
      end else if (sclk_rise) begin
        case (tx_state)
          TX_IDLE: begin
            if (full) begin
              miso     <= START_BIT;
              full     <= 1'b0;
              tx_idx   <= IDX_MSB;
              tx_state <= TX_DATA;
            end
          end
          TX_DATA: begin
            miso <= tx_sh[tx_idx];
            if (tx_idx == '0) tx_state <= TX_STOP;
            else              tx_idx   <= tx_idx - 1'b1;
          end
          TX_STOP: begin
            miso     <= STOP_BIT;
            tx_state <= TX_IDLE;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // TX datapath: holding register load and hand-off to the shift register.
  always_ff @(posedge clock_in) begin
    if (tx_valid && !full) hold <= tx_data;
    if (!cs_s && sclk_rise && tx_state == TX_IDLE && full) tx_sh <= hold;
  end

  assign tx_ready = ~full;
  assign busy     = (rx_state != RX_IDLE) || (tx_state != TX_IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed plan plus randomized frames vs a frame-level model.
module tb_spi_slave;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic       clock_in = 1'b0;
  logic       rs       = 1'b1;
  logic       sclk     = 1'b0;
  logic       cs       = 1'b1;
  logic       mosi     = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso, tx_ready, rx_valid, rx_frame_err, busy;
  logic [7:0] rx_data;

  always #5 clock_in = ~clock_in;

  spi_slave #(.SYNC_STAGES(SYNC_STAGES), .DATA_BITS(8)) dut (
    .clock_in(clock_in), .rs(rs), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Strobe monitor: counts pulses and flags any strobe lasting more than one cycle.
  int   n_valid = 0, n_err = 0, n_long = 0;
  logic prev_v = 1'b0, prev_e = 1'b0;
  always @(negedge clock_in) begin
    if (rx_valid) begin
      n_valid <= n_valid + 1;
      if (prev_v) n_long <= n_long + 1;
    end
    if (rx_frame_err) begin
      n_err <= n_err + 1;
      if (prev_e) n_long <= n_long + 1;
    end
    prev_v <= rx_valid;
    prev_e <= rx_frame_err;
  end

  // Frame-level reference model.
  logic [7:0] m_rx_data = 8'h00;
  bit         m_pending = 1'b0;
  logic [7:0] m_byte    = 8'h00;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},     32'(miso),         32'd1);
    check({tag, "_tx_ready"}, 32'(tx_ready),     32'd1);
    check({tag, "_rx_data"},  32'(rx_data),      32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid),     32'd0);
    check({tag, "_frm_err"},  32'(rx_frame_err), 32'd0);
    check({tag, "_busy"},     32'(busy),         32'd0);
  endtask

  task automatic load_byte(input logic [7:0] b);
    @(negedge clock_in);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock_in);
    tx_valid = 1'b0;
    check("ready_after_load", 32'(tx_ready), 32'd0);
    if (!m_pending) begin
      m_pending = 1'b1;
      m_byte    = b;
    end
  endtask

  // Master frame: nbits of {start, b, stop}; miso sampled just before each fall.
  task automatic frame(input logic [7:0] b, input bit stop_ok, input int nbits, input bit end_cs);
    logic [9:0] sent, exp_miso, seen;
    int         v0, e0, l0;
    bit         had_pending;
    sent        = {1'b0, b, stop_ok};
    had_pending = m_pending;
    exp_miso    = had_pending ? {1'b0, m_byte, 1'b1} : 10'h3FF;
    if (had_pending && nbits > 0) m_pending = 1'b0;
    v0 = n_valid; e0 = n_err; l0 = n_long;
    seen = '1;
    @(negedge clock_in);
    cs = 1'b0;
    repeat (4) @(negedge clock_in);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      mosi = sent[9-i];
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clock_in);
        if (i == 0 && had_pending && k <= 3)
          check("tx_ready_lat", 32'(tx_ready), 32'(k > SYNC_STAGES));
      end
      seen[9-i] = miso;
      sclk = 1'b0;
      repeat (HALF) @(negedge clock_in);
    end
    check("miso_bits", 32'(seen >> (10 - nbits)), 32'(exp_miso >> (10 - nbits)));
    if (end_cs) begin
      cs   = 1'b1;
      mosi = 1'b1;
      repeat (6) @(negedge clock_in);
      if (nbits == 10 && stop_ok) m_rx_data = b;
      check("rx_valid_cnt", 32'(n_valid - v0), 32'((nbits == 10 && stop_ok) ? 1 : 0));
      check("frame_err_cnt", 32'(n_err - e0), 32'((nbits == 10 && !stop_ok) ? 1 : 0));
      check("strobe_width", 32'(n_long - l0), 32'd0);
      check("rx_data", 32'(rx_data), 32'(m_rx_data));
      check("busy_idle", 32'(busy), 32'd0);
      check("miso_idle", 32'(miso), 32'd1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    logic [7:0] b;
    bit ok;

    repeat (3) @(negedge clock_in);
    check_reset_outputs("reset");
    rs = 1'b0;
    repeat (6) @(negedge clock_in);

    // Plain receive.
    frame(8'hA9, 1'b1, 10, 1'b1);

    // Transmit 0x5C while receiving 0xA9.
    load_byte(8'h5C);
    frame(8'hA9, 1'b1, 10, 1'b1);

    // Bad stop bit keeps the previous byte.
    frame(8'h3C, 1'b0, 10, 1'b1);

    // Abort after 4 data bits in both directions, then a clean frame.
    load_byte(8'hC3);
    frame(8'h96, 1'b1, 5, 1'b1);
    frame(8'h3C, 1'b1, 10, 1'b1);

    // No byte loaded, then tx_valid held while full.
    frame(8'h12, 1'b1, 10, 1'b1);
    load_byte(8'hE7);
    @(negedge clock_in);
    tx_data  = 8'h18;
    tx_valid = 1'b1;
    repeat (5) @(negedge clock_in);
    check("ready_held", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    frame(8'h55, 1'b1, 10, 1'b1);

    // Asynchronous reset mid-frame.
    load_byte(8'hAA);
    frame(8'h0F, 1'b1, 5, 1'b0);
    @(posedge clock_in);
    #3;
    rs = 1'b1;
    #1;
    check_reset_outputs("midreset");
    cs   = 1'b1;
    mosi = 1'b1;
    sclk = 1'b0;
    m_rx_data = 8'h00;
    m_pending = 1'b0;
    repeat (3) @(negedge clock_in);
    rs = 1'b0;
    repeat (6) @(negedge clock_in);
    frame(8'hFF, 1'b1, 10, 1'b1);

    // Randomized frames: random data, stop errors, aborts and TX loads.
    for (int it = 0; it < 24; it++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 9)) : 10;
      if ($urandom_range(0, 1) == 1) load_byte(8'($urandom));
      frame(b, ok, nb, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
